conv_encoder_frame: RTL and testbench

Parametrised, frame-based convolutional encoder with valid/ready streaming on both sides, generalising the fixed-width encoder path of `endec` to run-time constraint length 3..MAX_K and code rate 1/2..1/MAX_N. It accepts one information bit per handshake and emits one MAX_N-bit code symbol per handshake. Each frame of FRAME_LEN bits is optionally zero-terminated with K-1 tail symbols. The block sits between the bit source and the symbol framer that feeds the decoder's 384-bit frame input.

---
 rtl/endec_pkg.sv | 20 ++
 rtl/conv_encoder_frame_if.sv | 36 +++
 rtl/conv_sym_gen.sv | 30 +++
 rtl/conv_encoder_frame.sv | 193 +++++++++++++++++++
 tb/tb_conv_encoder_frame.sv | 303 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/endec_pkg.sv
// Shared encoder/decoder definitions: FSM states, default geometry and the config legality check.
package endec_pkg;

    localparam int unsigned MaxConstrLen = 5;    // matches MAX_CONSTRAINT_LENGTH
    localparam int unsigned MaxCodeRate  = 3;    // matches MAX_CODE_RATE
    localparam int unsigned FrameLenDef  = 128;

    typedef enum logic [1:0] {
        StIdle,
        StData,
        StTail
    } enc_state_e;

    // K must leave at least two memory bits; N must give at least rate 1/2.
    function automatic logic cfg_legal(input int unsigned k, input int unsigned n,
                                       input int unsigned max_k, input int unsigned max_n);
        return (k >= 3) && (k <= max_k) && (n >= 2) && (n <= max_n);
    endfunction

endpackage

// File: rtl/conv_encoder_frame_if.sv
// Control, configuration and bit/symbol stream bundle of the frame encoder.
interface conv_encoder_frame_if #(
    parameter int unsigned MAX_K = 5,
    parameter int unsigned MAX_N = 3
);
    localparam int unsigned KW = $clog2(MAX_K + 1);
    localparam int unsigned NW = $clog2(MAX_N + 1);

    logic                   en;
    logic                   i_start;
    logic [KW-1:0]          i_constr_len;
    logic [NW-1:0]          i_code_rate;
    logic [MAX_K*MAX_N-1:0] i_gen_poly_flat;
    logic                   i_bit_valid;
    logic                   i_bit;
    logic                   o_bit_ready;
    logic                   o_sym_valid;
    logic [MAX_N-1:0]       o_sym;
    logic                   o_last;
    logic                   i_sym_ready;
    logic                   o_frame_done;
    logic                   o_cfg_err;

    modport master (
        output en, i_start, i_constr_len, i_code_rate, i_gen_poly_flat,
        output i_bit_valid, i_bit, i_sym_ready,
        input  o_bit_ready, o_sym_valid, o_sym, o_last, o_frame_done, o_cfg_err
    );

    modport slave (
        input  en, i_start, i_constr_len, i_code_rate, i_gen_poly_flat,
        input  i_bit_valid, i_bit, i_sym_ready,
        output o_bit_ready, o_sym_valid, o_sym, o_last, o_frame_done, o_cfg_err
    );

endinterface

// File: rtl/conv_sym_gen.sv
// Combinational code symbol generator: parity of each generator polynomial over the window.
module conv_sym_gen #(
    parameter int unsigned MAX_K = 5,
    parameter int unsigned MAX_N = 3
) (
    input  logic [MAX_K-1:0]           window,
    input  logic [MAX_K*MAX_N-1:0]     polys,
    input  logic [$clog2(MAX_K+1)-1:0] k,
    input  logic [$clog2(MAX_N+1)-1:0] n,
    output logic [MAX_N-1:0]           sym
);
    localparam int unsigned KW = $clog2(MAX_K + 1);
    localparam int unsigned NW = $clog2(MAX_N + 1);

    logic [MAX_K-1:0] tap_mask;

    always_comb begin
        tap_mask = '0;
        for (int i = 0; i < MAX_K; i++) begin
            tap_mask[i] = (KW'(i) < k);
        end
        sym = '0;
        for (int j = 0; j < MAX_N; j++) begin
            if (NW'(j) < n) begin
                sym[j] = ^(window & polys[j*MAX_K +: MAX_K] & tap_mask);
            end
        end
    end

endmodule

// File: rtl/conv_encoder_frame.sv
// Frame-based convolutional encoder with run-time K and N and valid/ready streaming.
// Define CONV_TAIL_FLUSH_EN to append K-1 zero-input tail symbols to every frame.
module conv_encoder_frame
    import endec_pkg::*;
#(
    parameter int unsigned MAX_K     = MaxConstrLen,
    parameter int unsigned MAX_N     = MaxCodeRate,
    parameter int unsigned FRAME_LEN = FrameLenDef
) (
    input logic               sys_clk,
    input logic               rst,
    conv_encoder_frame_if.slave bus
);
    localparam int unsigned KW = $clog2(MAX_K + 1);
    localparam int unsigned NW = $clog2(MAX_N + 1);
    localparam int unsigned CW = $clog2(FRAME_LEN + 1);
    localparam int unsigned SW = MAX_K - 1;
    localparam int unsigned PW = MAX_K * MAX_N;

    enc_state_e       state_q, state_d;
    logic [KW-1:0]    k_q, k_d;
    logic [NW-1:0]    n_q, n_d;
    logic [PW-1:0]    poly_q, poly_d;
    logic [SW-1:0]    shreg_q, shreg_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [MAX_N-1:0] sym_q, sym_d;
    logic             sym_valid_q, sym_valid_d;
    logic             last_q, last_d;
    logic             frame_done_q, frame_done_d;
    logic             cfg_err_q, cfg_err_d;

`ifdef CONV_TAIL_FLUSH_EN
    logic [KW-1:0]    tail_q, tail_d;
`endif

    logic             bit_ready;
    logic             slot_free;
    logic             sym_hs;
    logic             load;
    logic             load_last;
    logic             in_bit;
    logic [MAX_N-1:0] gen_sym;

    // Tail symbols are the trellis driven with forced-zero input.
    assign in_bit = (state_q == StData) ? bus.i_bit : 1'b0;

    conv_sym_gen #(
        .MAX_K (MAX_K),
        .MAX_N (MAX_N)
    ) u_sym_gen (
        .window (({shreg_q, in_bit})),
        .polys  (poly_q),
        .k      (k_q),
        .n      (n_q),
        .sym    (gen_sym)
    );

    assign slot_free = !sym_valid_q || bus.i_sym_ready;
    assign sym_hs    = bus.en && sym_valid_q && bus.i_sym_ready;

    always_comb begin
        state_d      = state_q;
        k_d          = k_q;
        n_d          = n_q;
        poly_d       = poly_q;
        shreg_d      = shreg_q;
        cnt_d        = cnt_q;
        frame_done_d = frame_done_q;
        cfg_err_d    = cfg_err_q;
        bit_ready    = 1'b0;
        load         = 1'b0;
        load_last    = 1'b0;
`ifdef CONV_TAIL_FLUSH_EN
        tail_d       = tail_q;
`endif
        if (bus.en) begin
            frame_done_d = 1'b0;
            cfg_err_d    = 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (bus.i_start) begin
                        if (cfg_legal(32'(bus.i_constr_len), 32'(bus.i_code_rate),
                                      MAX_K, MAX_N)) begin
                            k_d     = bus.i_constr_len;
                            n_d     = bus.i_code_rate;
                            poly_d  = bus.i_gen_poly_flat;
                            shreg_d = '0;
                            cnt_d   = '0;
`ifdef CONV_TAIL_FLUSH_EN
                            tail_d  = '0;
`endif
                            state_d = StData;
                        end else begin
                            cfg_err_d = 1'b1;
                        end
                    end
                end
                StData: begin
                    // Without a tail the FSM idles here after the last bit until it drains.
                    bit_ready = slot_free && (cnt_q != CW'(FRAME_LEN));
                    if (bus.i_bit_valid && bit_ready) begin
                        load    = 1'b1;
                        shreg_d = {shreg_q[SW-2:0], bus.i_bit};
                        cnt_d   = cnt_q + CW'(1);
                        if (cnt_q == CW'(FRAME_LEN - 1)) begin
`ifdef CONV_TAIL_FLUSH_EN
                            state_d = StTail;
`else
                            load_last = 1'b1;
`endif
                        end
                    end
                end
`ifdef CONV_TAIL_FLUSH_EN
                StTail: begin
                    if (slot_free && (tail_q != k_q - KW'(1))) begin
                        load      = 1'b1;
                        shreg_d   = {shreg_q[SW-2:0], 1'b0};
                        tail_d    = tail_q + KW'(1);
                        load_last = (tail_q == k_q - KW'(2));
                    end
                end
`endif
                default: state_d = StIdle;
            endcase
            if (sym_hs && last_q && !load) begin
                state_d      = StIdle;
                frame_done_d = 1'b1;
            end
        end
    end

    always_comb begin
        sym_d       = sym_q;
        sym_valid_d = sym_valid_q;
        last_d      = last_q;
        if (load) begin
            sym_d       = gen_sym;
            sym_valid_d = 1'b1;
            last_d      = load_last;
        end else if (sym_hs) begin
            sym_valid_d = 1'b0;
            last_d      = 1'b0;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state_q      <= StIdle;
            k_q          <= '0;
            n_q          <= '0;
            poly_q       <= '0;
            shreg_q      <= '0;
            cnt_q        <= '0;
            sym_q        <= '0;
            sym_valid_q  <= 1'b0;
            last_q       <= 1'b0;
            frame_done_q <= 1'b0;
            cfg_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            k_q          <= k_d;
            n_q          <= n_d;
            poly_q       <= poly_d;
            shreg_q      <= shreg_d;
            cnt_q        <= cnt_d;
            sym_q        <= sym_d;
            sym_valid_q  <= sym_valid_d;
            last_q       <= last_d;
            frame_done_q <= frame_done_d;
            cfg_err_q    <= cfg_err_d;
        end
    end

`ifdef CONV_TAIL_FLUSH_EN
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            tail_q <= '0;
        end else begin
            tail_q <= tail_d;
        end
    end
`endif

    assign bus.o_bit_ready  = bit_ready;
    assign bus.o_sym_valid  = sym_valid_q;
    assign bus.o_sym        = sym_q;
    assign bus.o_last       = last_q;
    // Pulses are held while disabled and surface once en returns.
    assign bus.o_frame_done = frame_done_q && bus.en;
    assign bus.o_cfg_err    = cfg_err_q && bus.en;

endmodule

// File: tb/tb_conv_encoder_frame.sv
// Scoreboard bench for conv_encoder_frame: a convolution reference model fills the queue,
// a negedge monitor pops on every symbol handshake.
module tb_conv_encoder_frame;
    import endec_pkg::*;

    localparam int unsigned MK = 5;
    localparam int unsigned MN = 3;
    localparam int unsigned FL = 4;
    localparam int unsigned PW = MK * MN;
    localparam int unsigned KW = $clog2(MK + 1);
    localparam int unsigned NW = $clog2(MN + 1);

    logic sys_clk = 1'b0;
    logic rst;
    always #5 sys_clk = ~sys_clk;

    conv_encoder_frame_if #(.MAX_K(MK), .MAX_N(MN)) bus ();

    conv_encoder_frame #(
        .MAX_K     (MK),
        .MAX_N     (MN),
        .FRAME_LEN (FL)
    ) dut (
        .sys_clk (sys_clk),
        .rst     (rst),
        .bus     (bus)
    );

    int checks = 0;
    int errors = 0;
    logic [MN:0] exp_q[$];   // {last, symbol}
    int frames_done = 0;
    bit mon_on = 0;
    bit cfg_allowed = 0;
    bit expect_done = 0;
    bit prev_stall = 0;
    logic [MN-1:0] prev_sym;
    logic prev_last;

    localparam logic [PW-1:0] DPoly = 15'b00000_00101_00111;
    localparam logic [FL-1:0] DBits = 4'b1101;  // bit 0 first: 1,0,1,1

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference: symbol t, bit j = XOR over taps i<K of poly_j[i] & u[t-i], u zero outside frame.
    function automatic void push_model(input int k, input int n, input logic [PW-1:0] poly,
                                       input logic [FL-1:0] bits);
        int total = FL;
`ifdef CONV_TAIL_FLUSH_EN
        total = FL + k - 1;
`endif
        for (int t = 0; t < total; t++) begin
            logic [MN:0] e;
            e = '0;
            for (int j = 0; j < n; j++) begin
                bit p;
                p = 1'b0;
                for (int i = 0; i < k; i++) begin
                    if (t - i >= 0 && t - i < int'(FL)) p = p ^ (poly[j*MK+i] & bits[t-i]);
                end
                e[j] = p;
            end
            e[MN] = (t == total - 1);
            exp_q.push_back(e);
        end
    endfunction

    task automatic push_directed();
        exp_q.push_back({1'b0, 3'd3});
        exp_q.push_back({1'b0, 3'd1});
        exp_q.push_back({1'b0, 3'd0});
`ifdef CONV_TAIL_FLUSH_EN
        exp_q.push_back({1'b0, 3'd2});
        exp_q.push_back({1'b0, 3'd2});
        exp_q.push_back({1'b1, 3'd3});
`else
        exp_q.push_back({1'b1, 3'd2});
`endif
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_sym_valid"}, int'(bus.o_sym_valid), 0);
        check({tag, "_sym"}, int'(bus.o_sym), 0);
        check({tag, "_last"}, int'(bus.o_last), 0);
        check({tag, "_bit_ready"}, int'(bus.o_bit_ready), 0);
        check({tag, "_frame_done"}, int'(bus.o_frame_done), 0);
        check({tag, "_cfg_err"}, int'(bus.o_cfg_err), 0);
    endtask

    // Monitor: scoreboard pop, stall stability, frame_done timing, enable gating.
    always @(negedge sys_clk) begin
        if (rst) begin
            prev_stall  = 0;
            expect_done = 0;
        end else begin
            if (mon_on) begin
                if (prev_stall) begin
                    check("stall_sym_hold", int'(bus.o_sym), int'(prev_sym));
                    check("stall_last_hold", int'(bus.o_last), int'(prev_last));
                    check("stall_valid_hold", int'(bus.o_sym_valid), 1);
                end
                if (bus.o_sym_valid && !bus.i_sym_ready)
                    check("ready_while_stalled", int'(bus.o_bit_ready), 0);
                if (!bus.en) begin
                    check("en_low_bit_ready", int'(bus.o_bit_ready), 0);
                    check("en_low_frame_done", int'(bus.o_frame_done), 0);
                end
                if (expect_done && bus.en) begin
                    check("frame_done_pulse", int'(bus.o_frame_done), 1);
                    expect_done = 0;
                    frames_done++;
                end else if (bus.o_frame_done) begin
                    check("frame_done_spurious", int'(bus.o_frame_done), 0);
                end
                if (bus.o_cfg_err && !cfg_allowed)
                    check("cfg_err_spurious", int'(bus.o_cfg_err), 0);
                if (bus.en && bus.o_sym_valid && bus.i_sym_ready) begin
                    if (exp_q.size() == 0) begin
                        check("sym_unexpected", int'(bus.o_sym_valid), 0);
                    end else begin
                        logic [MN:0] e;
                        e = exp_q.pop_front();
                        check("sym", int'(bus.o_sym), int'(e[MN-1:0]));
                        check("last", int'(bus.o_last), int'(e[MN]));
                        if (e[MN]) expect_done = 1;
                    end
                end
            end
            prev_stall = bus.o_sym_valid && !(bus.en && bus.i_sym_ready);
            prev_sym   = bus.o_sym;
            prev_last  = bus.o_last;
        end
    end

    task automatic start_frame(input int k, input int n, input logic [PW-1:0] poly);
        bus.en              = 1'b1;
        bus.i_start         = 1'b1;
        bus.i_constr_len    = KW'(k);
        bus.i_code_rate     = NW'(n);
        bus.i_gen_poly_flat = poly;
        bus.i_bit_valid     = 1'b0;
        bus.i_sym_ready     = 1'b1;
        @(posedge sys_clk);
        #1;
        bus.i_start = 1'b0;
    endtask

    // ready_mode: 0 always ready, 1 toggling, 2 random. en_mode: 0 on, 1 fixed gaps, 2 random.
    task automatic run_frame(input int k, input int n, input logic [PW-1:0] poly,
                             input logic [FL-1:0] bits, input int ready_mode, input int en_mode);
        int idx = 0;
        int cyc = 0;
        int burst = 0;
        int fd0 = frames_done;
        bit acc;
        start_frame(k, n, poly);
        while (frames_done == fd0 && cyc < 400) begin
            bus.i_bit_valid = (idx < int'(FL)) && ($urandom_range(0, 3) != 0);
            bus.i_bit       = (idx < int'(FL)) ? bits[idx] : 1'($urandom);
            case (ready_mode)
                0:       bus.i_sym_ready = 1'b1;
                1:       bus.i_sym_ready = cyc[0];
                default: bus.i_sym_ready = 1'($urandom);
            endcase
            if (en_mode == 1) begin
                bus.en = !((cyc >= 2 && cyc <= 4) || (cyc >= 7 && cyc <= 9));
            end else if (en_mode == 2) begin
                if (burst > 0) begin
                    bus.en = 1'b0;
                    burst--;
                end else if ($urandom_range(0, 11) == 0) begin
                    bus.en = 1'b0;
                    burst  = $urandom_range(0, 2);
                end else begin
                    bus.en = 1'b1;
                end
            end else begin
                bus.en = 1'b1;
            end
            // Junk start/config while mid-frame must be ignored.
            bus.i_start = (idx < int'(FL)) && ($urandom_range(0, 5) == 0);
            if (bus.i_start) begin
                bus.i_constr_len    = KW'($urandom_range(0, 7));
                bus.i_code_rate     = NW'($urandom_range(0, 3));
                bus.i_gen_poly_flat = PW'($urandom);
            end
            @(negedge sys_clk);
            acc = bus.i_bit_valid && bus.o_bit_ready;
            if (acc && idx >= int'(FL)) check("extra_bit_accept", idx + 1, int'(FL));
            if (acc) idx++;
            @(posedge sys_clk);
            #1;
            cyc++;
        end
        bus.i_start     = 1'b0;
        bus.i_bit_valid = 1'b0;
        bus.i_sym_ready = 1'b1;
        bus.en          = 1'b1;
        check("frame_completed", frames_done - fd0, 1);
        check("bits_consumed", idx, int'(FL));
        check("queue_drained", exp_q.size(), 0);
        if (frames_done == fd0) begin
            rst = 1'b1;
            @(posedge sys_clk);
            #1;
            rst = 1'b0;
            exp_q.delete();
        end
    endtask

    task automatic cfg_err_case(input int k, input int n);
        cfg_allowed         = 1;
        bus.en              = 1'b1;
        bus.i_start         = 1'b1;
        bus.i_constr_len    = KW'(k);
        bus.i_code_rate     = NW'(n);
        bus.i_gen_poly_flat = DPoly;
        @(posedge sys_clk);
        #1;
        bus.i_start = 1'b0;
        check("cfg_err_pulse", int'(bus.o_cfg_err), 1);
        check("cfg_err_bit_ready", int'(bus.o_bit_ready), 0);
        @(posedge sys_clk);
        #1;
        check("cfg_err_clears", int'(bus.o_cfg_err), 0);
        check("cfg_err_stays_idle", int'(bus.o_bit_ready), 0);
        cfg_allowed = 0;
    endtask

    initial begin
        rst                 = 1'b1;
        bus.en              = 1'b0;
        bus.i_start         = 1'b0;
        bus.i_constr_len    = '0;
        bus.i_code_rate     = '0;
        bus.i_gen_poly_flat = '0;
        bus.i_bit_valid     = 1'b0;
        bus.i_bit           = 1'b0;
        bus.i_sym_ready     = 1'b1;
        repeat (3) @(posedge sys_clk);
        #1;
        check_reset("reset");
        rst    = 1'b0;
        mon_on = 1;

        push_directed();
        run_frame(3, 2, DPoly, DBits, 0, 0);
        push_directed();
        run_frame(3, 2, DPoly, DBits, 1, 0);
        push_directed();
        run_frame(3, 2, DPoly, DBits, 0, 1);

        cfg_err_case(2, 2);
        cfg_err_case(6, 2);
        cfg_err_case(3, 1);
        cfg_err_case(3, 0);

        // Reset after two accepted bits discards the partial frame.
        mon_on = 0;
        start_frame(3, 2, DPoly);
        for (int b = 0; b < 2; b++) begin
            bus.i_bit_valid = 1'b1;
            bus.i_bit       = DBits[b];
            @(negedge sys_clk);
            check("pre_reset_ready", int'(bus.o_bit_ready), 1);
            @(posedge sys_clk);
            #1;
        end
        bus.i_bit_valid = 1'b0;
        rst = 1'b1;
        @(posedge sys_clk);
        #1;
        check_reset("mid_reset");
        rst = 1'b0;
        exp_q.delete();
        mon_on = 1;
        push_directed();
        run_frame(3, 2, DPoly, DBits, 2, 0);

        for (int f = 0; f < 40; f++) begin
            int k;
            int n;
            logic [PW-1:0] poly;
            logic [FL-1:0] bits;
            k    = $urandom_range(3, MK);
            n    = $urandom_range(2, MN);
            poly = PW'($urandom);
            bits = FL'($urandom);
            push_model(k, n, poly, bits);
            run_frame(k, n, poly, bits, $urandom_range(0, 2), 2);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
